// File: rtl/dpram_param_clr.sv
// -----------------------------------------------------------------------------
// dpram_param_clr
// Simple dual-port RAM (one write port, one registered read port) that
// zeroes its own contents after every reset before accepting traffic.
//
// Parameters
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : address width, DEPTH = 2**ADDR_WIDTH
//   RDW_MODE   : same-address read-during-write, 0 = old data, 1 = new data
//
// Ports
//   clk       : single rising-edge clock
//   rst_n     : synchronous active-low reset
//   wen       : write enable
//   waddr     : write address
//   data_in   : write data
//   ren       : read enable
//   raddr     : read address
//   data_out  : registered read data
//   init_busy : high while the clear sequence is running
//
// Build option
//   DPRAM_PARAM_CLR_OUTREG_EN : adds a second output register stage
//                               (read latency 2 instead of 1)
//
// FSM
//   state | meaning
//   CLEAR | writing zero to every location, user traffic ignored
//   READY | normal read/write operation
// -----------------------------------------------------------------------------
module dpram_param_clr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  init_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // The single physical write port is shared between the clear sweep and
  // user writes; the FSM selects which one owns it.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    mem_we      = 1'b0;
    mem_wa      = waddr;
    mem_wd      = data_in;
    case (state)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_wa      = clr_cnt;
        mem_wd      = '0;
        // Counter wraps back to 0 on the last location, leaving it ready
        // for the next reset-triggered sweep.
        clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
        if (clr_cnt == {ADDR_WIDTH{1'b1}}) state_nxt = READY;
      end
      READY: begin
        mem_we = wen;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Memory has no reset of its own; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || state == CLEAR) begin
      rd_q <= '0;
    end else if (ren) begin
      if (RDW_MODE != 0 && wen && waddr == raddr) rd_q <= data_in;
      else                                         rd_q <= mem[raddr];
    end
  end

  assign init_busy = (state == CLEAR);

`ifdef DPRAM_PARAM_CLR_OUTREG_EN
  logic                  ren_d;
  logic [DATA_WIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ren_d <= 1'b0;
      out_q <= '0;
    end else begin
      ren_d <= ren && (state == READY);
      if (ren_d) out_q <= rd_q;
    end
  end

  assign data_out = out_q;
`else
  assign data_out = rd_q;
`endif

endmodule
